fetch_npc_unit: RTL and testbench
=================================

Name: fetch_npc_unit

Overview:
- Multi-cycle MIPS instruction-fetch and next-PC stage.
- Sits upstream of the multi-cycle controller and consumes its pc_wr, ir_wr and npc_sel outputs.
- Holds PC and IR, and runs a req/ack handshake to instruction memory so fetch may take wait states; signals completion with fetch_done.
- Computes jump, jr and branch targets, and exports the link address for jal/bltzal.

Parameters:
RESET_PC, 32'h0000_3000, PC value after reset
ACK_TIMEOUT, 16, max cycles in REQ before abort; 0 = no timeout

Ports:
clk  in  1  clock
rst  in  1  reset
ir_wr  in  1  start fetch of instruction at pc
pc_wr  in  1  load pc with npc (jump/branch)
npc_sel  in  2  00 pc+4, 01 j/jal, 10 jr, 11 beq/bltzal
rs_data  in  32  GPR[rs], jr target
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_rdata  in  32  instruction word, valid when imem_ack
imem_ack  in  1  request accepted, data valid
pc  out  32  current PC
pc_link  out  32  link value for jal/bltzal (equals pc)
ir  out  32  instruction register
fetch_busy  out  1  high in REQ or DONE
fetch_done  out  1  one-cycle pulse, ir valid
addr_err  out  1  sticky: misaligned target or fetch timeout

Behaviour:
Reset (rst is asynchronous, active-high; clock is clk):
- pc=RESET_PC, ir=0, state=IDLE.
- imem_req=0, fetch_done=0, addr_err=0, timeout counter=0.

FSM: IDLE, REQ, DONE (2-bit encoding).
- IDLE: ir_wr sampled high -> REQ; latch fetch address = pc; clear timeout counter.
- REQ: imem_req=1, imem_addr=latched address, held stable until ack.
  - imem_ack sampled high at edge: ir<=imem_rdata, pc<=address+4, -> DONE.
  - ACK_TIMEOUT!=0 and counter reaches ACK_TIMEOUT-1 without ack: addr_err<=1, ir<=32'h0 (nop), pc unchanged, -> DONE.
- DONE: fetch_done=1 for exactly one cycle -> IDLE.
- imem_req, fetch_busy, fetch_done decode from state only (no combinational path from inputs).

Timing:
- Minimum latency: ir_wr at edge 0 -> imem_req during cycle 1 -> capture at edge 1 (zero-wait ack) -> fetch_done high during cycle 2.
- Each extra cycle of imem_ack low adds one cycle.

pc_wr:
- Honoured only in IDLE with ir_wr low; at that edge pc<=npc.
- pc_wr together with ir_wr: ir_wr wins; fetch starts, pc_wr is dropped (controller s0 asserts both; the sequential increment happens at ack).
- pc_wr or ir_wr in REQ/DONE: ignored, no effect.

npc (combinational, uses current pc = fetched instruction +4):
- 00: pc+4
- 01: {pc[31:28], ir[25:0], 2'b00}
- 10: rs_data
- 11: pc + (sign_extend(ir[15:0]) << 2), 32-bit wrap-around, no overflow flag
- Loaded target with [1:0]!=0: pc gets {target[31:2],2'b00}, addr_err<=1.

Other rules:
- addr_err clears only on rst.
- pc_link is combinationally equal to pc.
- Late imem_ack in IDLE/DONE is ignored.
- rst mid-fetch: imem_req drops immediately (async); the in-flight response is discarded.
- pc+4 from 32'hFFFF_FFFC wraps to 0.

Decomposition:
- Package fetch_pkg:
  - NPC_SEQ/NPC_J/NPC_JR/NPC_BR encodings
  - FSM state encodings IDLE/REQ/DONE
  - default RESET_PC
  - NOP_WORD=32'h0
- One combinational sub-module, npc_calc: inputs pc, ir, rs_data, npc_sel; outputs npc and misalign.

Test Plan:
- Reset then ir_wr with zero-wait memory returning 32'h3C01_1234 -> imem_addr=0x3000, ir=0x3C011234, pc=0x3004, fetch_done pulse in cycle 2.
- Fetch with imem_ack delayed 3 cycles -> imem_req and imem_addr held stable 4 cycles; ir_wr/pc_wr pulses meanwhile ignored; single fetch_done.
- pc=0x3008, ir=beq with imm 16'hFFFE, npc_sel=11, pc_wr -> pc=0x3000; imm 16'h0004 -> pc=0x3018.
- ir=j 26'h0000C10, npc_sel=01, pc_wr -> pc=0x0000_3040; jr rs_data=0x3006, npc_sel=10 -> pc=0x3004, addr_err=1.
- ir_wr and pc_wr same cycle (npc_sel=01) -> fetch from old pc, pc=old+4 after ack.
- rst asserted during REQ -> imem_req low immediately, pc=0x3000; subsequent stray ack ignored. With ACK_TIMEOUT=4 and no ack -> addr_err=1, ir=0, fetch_done pulse.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings and constants for the fetch / next-PC stage.
package fetch_pkg;
  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_J   = 2'b01;
  localparam logic [1:0] NPC_JR  = 2'b10;
  localparam logic [1:0] NPC_BR  = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10} state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0;
endpackage

// File: rtl/fetch_npc_unit_npc_calc.sv
// npc_calc: combinational next-PC select (seq, j/jal, jr, branch) and misalignment flag.
module npc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] ir,
  input  logic [31:0] rs_data,
  input  logic [1:0]  npc_sel,
  output logic [31:0] npc,
  output logic        misalign
);
  logic [31:0] w_seq, w_j, w_br;
  always_comb begin
    w_seq = pc + 32'd4;
    w_j = {pc[31:28], ir, 2'b00};
    w_br = pc + {{14{ir[15]}}, ir[15:0], 2'b00};
    npc = npc_sel == NPC_SEQ ? w_seq : npc_sel == NPC_J ? w_j : npc_sel == NPC_JR ? rs_data : w_br;
    misalign = |npc[1:0];
  end
endmodule

// File: rtl/fetch_npc_unit.sv
// fetch_npc_unit: multi-cycle MIPS fetch stage holding PC/IR with a req/ack imem handshake.
module fetch_npc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_wr,
  input  logic        pc_wr,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_link,
  output logic [31:0] ir,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        addr_err
);
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);
  state_t r_state;
  logic [31:0] r_pc, r_ir, r_addr;
  logic [15:0] r_cnt;
  logic r_err;
  logic [31:0] w_npc;
  logic w_mis, w_timeout;
  npc_calc u_npc (
    .pc(r_pc), .ir(r_ir[25:0]), .rs_data(rs_data), .npc_sel(npc_sel),
    .npc(w_npc), .misalign(w_mis)
  );
  assign w_timeout = ACK_TIMEOUT != 0 && r_cnt == TO_LAST;
  // ir_wr beats pc_wr in IDLE: the sequential increment is applied at ack instead
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_ir <= NOP_WORD;
      r_addr <= RESET_PC;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ir_wr) begin
            r_state <= REQ;
            r_addr <= r_pc;
            r_cnt <= '0;
          end else if (pc_wr) begin
            r_pc <= {w_npc[31:2], 2'b00};
            if (w_mis) r_err <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ack) begin
            r_ir <= imem_rdata;
            r_pc <= r_addr + 32'd4;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_ir <= NOP_WORD;
            r_err <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign imem_req = r_state == REQ;
  assign imem_addr = r_addr;
  assign fetch_busy = r_state != IDLE;
  assign fetch_done = r_state == DONE;
  assign pc = r_pc;
  assign pc_link = r_pc;
  assign ir = r_ir;
  assign addr_err = r_err;
endmodule

// File: tb/tb_fetch_npc_unit.sv
// tb_fetch_npc_unit: randomized self-checking bench against a behavioural PC/IR model.
module tb_fetch_npc_unit;
  logic clk = 1'b0, rst, ir_wr, pc_wr, imem_ack;
  logic [1:0] npc_sel;
  logic [31:0] rs_data, imem_rdata;
  logic imem_req, fetch_busy, fetch_done, addr_err;
  logic [31:0] imem_addr, pc, pc_link, ir;
  logic [31:0] m_pc, m_ir;
  logic m_err;
  int n_run = 0, n_fail = 0;

  fetch_npc_unit #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ir_wr(ir_wr), .pc_wr(pc_wr), .npc_sel(npc_sel), .rs_data(rs_data),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .pc(pc), .pc_link(pc_link), .ir(ir), .fetch_busy(fetch_busy), .fetch_done(fetch_done),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_target(input logic [1:0] sel, input logic [31:0] p, input logic [31:0] w, input logic [31:0] rs);
    case (sel)
      2'd0: return p + 32'd4;
      2'd1: return (p & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      2'd2: return rs;
      default: return p + 32'($signed(w[15:0])) * 32'd4;
    endcase
  endfunction

  task automatic model_fetch(input int wt, input logic [31:0] word);
    if (wt <= 3) begin
      m_ir = word;
      m_pc = m_pc + 32'd4;
    end else begin
      m_ir = 32'h0;
      m_err = 1'b1;
    end
  endtask

  task automatic do_pcwr(input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] t;
    @(negedge clk);
    npc_sel = sel;
    rs_data = rs;
    pc_wr = 1'b1;
    @(negedge clk);
    pc_wr = 1'b0;
    t = ref_target(sel, m_pc, m_ir, rs);
    if (t % 4 != 0) m_err = 1'b1;
    m_pc = t & ~32'h3;
  endtask

  // ack arrives after wt low cycles in REQ; noise toggles ir_wr/pc_wr while the request is open
  task automatic do_fetch(input int wt, input logic [31:0] word, input logic noise, input logic pcw,
                          output int reqc, output int donec, output int donek, output logic stab, output logic [31:0] a0);
    @(negedge clk);
    ir_wr = 1'b1;
    pc_wr = pcw;
    npc_sel = 2'b01;
    @(negedge clk);
    ir_wr = 1'b0;
    pc_wr = 1'b0;
    reqc = 0; donec = 0; donek = -1; stab = 1'b1; a0 = imem_addr;
    for (int k = 0; k < 12; k++) begin
      if (imem_req) begin
        reqc++;
        if (imem_addr !== a0) stab = 1'b0;
      end
      if (fetch_done) begin
        donec++;
        donek = k;
      end
      imem_ack = imem_req && k == wt;
      imem_rdata = imem_ack ? word : $urandom;
      ir_wr = noise && imem_req && $urandom_range(1);
      pc_wr = noise && imem_req && $urandom_range(1);
      npc_sel = 2'($urandom_range(3));
      rs_data = $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b0; ir_wr = 1'b0; pc_wr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    n_run += 3;
    if (pc !== m_pc) begin n_fail++; $display("FAIL %s pc: got %h expected %h", tag, pc, m_pc); end
    if (ir !== m_ir) begin n_fail++; $display("FAIL %s ir: got %h expected %h", tag, ir, m_ir); end
    if (addr_err !== m_err) begin n_fail++; $display("FAIL %s addr_err: got %b expected %b", tag, addr_err, m_err); end
  endtask

  task automatic test_reset;
    ir_wr = 0; pc_wr = 0; npc_sel = 0; rs_data = 0; imem_ack = 0; imem_rdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_pc = 32'h3000; m_ir = 32'h0; m_err = 1'b0;
    n_run += 5;
    if (pc !== 32'h3000) begin n_fail++; $display("FAIL reset pc: got %h expected 00003000", pc); end
    if (ir !== 32'h0) begin n_fail++; $display("FAIL reset ir: got %h expected 0", ir); end
    if ({imem_req, fetch_busy, fetch_done, addr_err} !== 4'b0) begin n_fail++; $display("FAIL reset flags: got %b expected 0000", {imem_req, fetch_busy, fetch_done, addr_err}); end
    if (pc_link !== 32'h3000) begin n_fail++; $display("FAIL reset pc_link: got %h expected 00003000", pc_link); end
    @(negedge clk);
    if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL reset idle busy: got %b expected 0", fetch_busy); end
  endtask

  task automatic test_basic;
    int rc, dc, dk; logic st; logic [31:0] a0;
    do_fetch(0, 32'h3C01_1234, 1'b0, 1'b0, rc, dc, dk, st, a0);
    model_fetch(0, 32'h3C01_1234);
    n_run += 5;
    if (a0 !== 32'h3000) begin n_fail++; $display("FAIL basic addr: got %h expected 00003000", a0); end
    if (ir !== 32'h3C01_1234) begin n_fail++; $display("FAIL basic ir: got %h expected 3c011234", ir); end
    if (pc !== 32'h3004) begin n_fail++; $display("FAIL basic pc: got %h expected 00003004", pc); end
    if (dk !== 1 || dc !== 1) begin n_fail++; $display("FAIL basic done: got k=%0d n=%0d expected k=1 n=1", dk, dc); end
    if (rc !== 1) begin n_fail++; $display("FAIL basic req cycles: got %0d expected 1", rc); end
  endtask

  task automatic test_wait;
    int rc, dc, dk; logic st; logic [31:0] a0;
    do_fetch(3, 32'hAABB_CCDD, 1'b1, 1'b0, rc, dc, dk, st, a0);
    model_fetch(3, 32'hAABB_CCDD);
    n_run += 3;
    if (rc !== 4 || st !== 1'b1) begin n_fail++; $display("FAIL wait req: got cycles=%0d stable=%b expected 4/1", rc, st); end
    if (dc !== 1 || dk !== 4) begin n_fail++; $display("FAIL wait done: got n=%0d k=%0d expected 1/4", dc, dk); end
    if (a0 !== 32'h3004) begin n_fail++; $display("FAIL wait addr: got %h expected 00003004", a0); end
    check_state("wait");
  endtask

  task automatic test_branch;
    int rc, dc, dk; logic st; logic [31:0] a0;
    do_pcwr(2'b10, 32'h3004);
    do_fetch(0, 32'h1000_FFFE, 1'b0, 1'b0, rc, dc, dk, st, a0);
    model_fetch(0, 32'h1000_FFFE);
    do_pcwr(2'b11, 32'h0);
    n_run++;
    if (pc !== 32'h3000) begin n_fail++; $display("FAIL beq back pc: got %h expected 00003000", pc); end
    do_pcwr(2'b10, 32'h3004);
    do_fetch(0, 32'h1000_0004, 1'b0, 1'b0, rc, dc, dk, st, a0);
    model_fetch(0, 32'h1000_0004);
    do_pcwr(2'b11, 32'h0);
    n_run++;
    if (pc !== 32'h3018) begin n_fail++; $display("FAIL beq fwd pc: got %h expected 00003018", pc); end
    do_pcwr(2'b00, 32'h0);
    check_state("branch");
  endtask

  task automatic test_simul;
    int rc, dc, dk; logic st; logic [31:0] a0, old;
    old = m_pc;
    do_fetch(1, 32'h0800_0001, 1'b0, 1'b1, rc, dc, dk, st, a0);
    model_fetch(1, 32'h0800_0001);
    n_run += 2;
    if (a0 !== old) begin n_fail++; $display("FAIL simul addr: got %h expected %h", a0, old); end
    if (pc !== old + 32'd4) begin n_fail++; $display("FAIL simul pc: got %h expected %h", pc, old + 32'd4); end
  endtask

  task automatic test_rst_mid;
    int dc = 0;
    @(negedge clk);
    ir_wr = 1'b1;
    @(negedge clk);
    ir_wr = 1'b0;
    n_run++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid req before: got %b expected 1", imem_req); end
    #2 rst = 1'b1;
    #1;
    n_run += 2;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid req async: got req=%b busy=%b expected 0/0", imem_req, fetch_busy); end
    if (pc !== 32'h3000) begin n_fail++; $display("FAIL rstmid pc: got %h expected 00003000", pc); end
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      if (fetch_done) dc++;
    end
    imem_ack = 1'b0;
    m_pc = 32'h3000; m_ir = 32'h0; m_err = 1'b0;
    n_run++;
    if (dc !== 0) begin n_fail++; $display("FAIL rstmid stray done: got %0d expected 0", dc); end
    check_state("rstmid");
  endtask

  task automatic test_timeout;
    int rc, dc, dk; logic st; logic [31:0] a0;
    do_fetch(99, 32'h1234_5678, 1'b1, 1'b0, rc, dc, dk, st, a0);
    model_fetch(99, 32'h1234_5678);
    n_run += 2;
    if (rc !== 4) begin n_fail++; $display("FAIL timeout req cycles: got %0d expected 4", rc); end
    if (dc !== 1 || dk !== 4) begin n_fail++; $display("FAIL timeout done: got n=%0d k=%0d expected 1/4", dc, dk); end
    check_state("timeout");
  endtask

  task automatic test_jump;
    int rc, dc, dk; logic st; logic [31:0] a0;
    do_fetch(0, 32'h0800_0C10, 1'b0, 1'b0, rc, dc, dk, st, a0);
    model_fetch(0, 32'h0800_0C10);
    do_pcwr(2'b01, 32'h0);
    n_run += 2;
    if (pc !== 32'h3040) begin n_fail++; $display("FAIL j pc: got %h expected 00003040", pc); end
    if (addr_err !== 1'b0) begin n_fail++; $display("FAIL j addr_err: got %b expected 0", addr_err); end
    do_pcwr(2'b10, 32'h3006);
    n_run += 2;
    if (pc !== 32'h3004) begin n_fail++; $display("FAIL jr pc: got %h expected 00003004", pc); end
    if (addr_err !== 1'b1) begin n_fail++; $display("FAIL jr addr_err: got %b expected 1", addr_err); end
  endtask

  task automatic test_wrap;
    int rc, dc, dk; logic st; logic [31:0] a0;
    do_pcwr(2'b10, 32'hFFFF_FFFC);
    do_fetch(2, 32'h0000_0020, 1'b0, 1'b0, rc, dc, dk, st, a0);
    model_fetch(2, 32'h0000_0020);
    n_run += 2;
    if (a0 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap addr: got %h expected fffffffc", a0); end
    if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap pc: got %h expected 00000000", pc); end
  endtask

  task automatic test_random;
    int rc, dc, dk, wt; logic st; logic [31:0] a0, w, old;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1)) begin
        wt = $urandom_range(5);
        w = $urandom;
        old = m_pc;
        do_fetch(wt, w, 1'b1, 1'($urandom_range(1)), rc, dc, dk, st, a0);
        model_fetch(wt, w);
        n_run++;
        if (a0 !== old || dc !== 1 || st !== 1'b1) begin n_fail++; $display("FAIL rand fetch %0d: got addr=%h done=%0d stable=%b expected %h/1/1", i, a0, dc, st, old); end
      end else begin
        do_pcwr(2'($urandom_range(3)), $urandom);
      end
      check_state("rand");
      n_run++;
      if (pc_link !== m_pc) begin n_fail++; $display("FAIL rand pc_link: got %h expected %h", pc_link, m_pc); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_branch();
    test_simul();
    test_rst_mid();
    test_timeout();
    test_reset();
    test_jump();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
